// File: rtl/exe_iter_divider_if.sv
// Divide request/result bundle between the EX stage and the iterative divider.
interface exe_iter_divider_if #(
   parameter int WIDTH = 32
);
   logic             ena;
   logic             sign;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             flush;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] r;
   logic             busy;
   logic             done;
   logic             stall_req;

   modport master (
      output ena, sign, dividend, divisor, flush,
      input  q, r, busy, done, stall_req
   );

   modport slave (
      input  ena, sign, dividend, divisor, flush,
      output q, r, busy, done, stall_req
   );
endinterface

// File: rtl/exe_iter_divider.sv
// Radix-2 restoring divider for the EX stage; one quotient bit per cycle,
// signed operands handled by magnitude division plus sign fix-up.
//
// state  | meaning
// S_IDLE | waiting for ena; accepts and latches operands
// S_CALC | WIDTH shift/subtract iterations
// S_DONE | q/r valid, done pulse, pipeline released
module exe_iter_divider #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic                clk,
   input  logic                rst,
   exe_iter_divider_if.slave   div_if
);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] rem_q, quo_q, dvs_q, dvd_raw_q, q_q, r_q;
   logic             qsign_q, rsign_q, dvz_q, done_q;

   logic             dvd_neg, dvs_neg;
   logic [WIDTH-1:0] dvd_mag, dvs_mag;
   logic [WIDTH:0]   partial;
   logic [WIDTH+1:0] trial;
   logic [WIDTH-1:0] rem_d, quo_d, q_d, r_d;

   always_comb begin
      dvd_neg = div_if.sign & div_if.dividend[WIDTH-1];
      dvs_neg = div_if.sign & div_if.divisor[WIDTH-1];
      dvd_mag = dvd_neg ? -div_if.dividend : div_if.dividend;
      dvs_mag = dvs_neg ? -div_if.divisor  : div_if.divisor;

      // Extra guard bit so the borrow is unambiguous even when the shifted
      // remainder already needs WIDTH+1 bits.
      partial = {rem_q, quo_q[WIDTH-1]};
      trial   = {1'b0, partial} - {2'b00, dvs_q};
      if (!trial[WIDTH+1]) begin
         rem_d = trial[WIDTH-1:0];
         quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
         rem_d = partial[WIDTH-1:0];
         quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end

      if (dvz_q) begin
         q_d = '1;
         r_d = dvd_raw_q;
      end else begin
         q_d = qsign_q ? -quo_d : quo_d;
         r_d = rsign_q ? -rem_d : rem_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvs_q     <= '0;
         dvd_raw_q <= '0;
         qsign_q   <= 1'b0;
         rsign_q   <= 1'b0;
         dvz_q     <= 1'b0;
         q_q       <= '0;
         r_q       <= '0;
         done_q    <= 1'b0;
      end else if (div_if.flush) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (div_if.ena) begin
                  rem_q     <= '0;
                  quo_q     <= dvd_mag;
                  dvs_q     <= dvs_mag;
                  dvd_raw_q <= div_if.dividend;
                  qsign_q   <= dvd_neg ^ dvs_neg;
                  rsign_q   <= dvd_neg;
                  dvz_q     <= (div_if.divisor == '0);
                  cnt_q     <= CNT_W'(WIDTH);
                  state_q   <= S_CALC;
               end
            end
            S_CALC: begin
               rem_q <= rem_d;
               quo_q <= quo_d;
               cnt_q <= cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  q_q     <= q_d;
                  r_q     <= r_d;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign div_if.q         = q_q;
   assign div_if.r         = r_q;
   assign div_if.done      = done_q;
   assign div_if.busy      = (state_q == S_CALC);
   assign div_if.stall_req = ~div_if.flush &
                             (((state_q == S_IDLE) & div_if.ena) | (state_q == S_CALC));

endmodule

// File: tb/tb_exe_iter_divider.sv
// Directed bench for exe_iter_divider: latency, signed/unsigned results,
// divide-by-zero, flush, async reset and back-to-back issue.
module tb_exe_iter_divider;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   exe_iter_divider_if #(.WIDTH(32)) dif ();

   exe_iter_divider #(.WIDTH(32), .CNT_W(6)) dut (
      .clk    (clk),
      .rst    (rst),
      .div_if (dif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issues one divide and holds ena until the done cycle; no checking here.
   task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int stalls,
                         output logic [31:0] qo, output logic [31:0] ro);
      lat    = -1;
      stalls = 0;
      qo     = '0;
      ro     = '0;
      @(posedge clk);
      #1;
      dif.ena      = 1'b1;
      dif.sign     = sgn;
      dif.dividend = a;
      dif.divisor  = b;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (dif.stall_req) stalls++;
         if (dif.done) begin
            lat = i;
            qo  = dif.q;
            ro  = dif.r;
            break;
         end
      end
      @(posedge clk);
      #1;
      dif.ena = 1'b0;
   endtask

   task automatic test_reset();
      checks++; if (dif.q !== 32'h0)       begin failures++; $display("FAIL reset_q got=%h exp=%h", dif.q, 32'h0); end
      checks++; if (dif.r !== 32'h0)       begin failures++; $display("FAIL reset_r got=%h exp=%h", dif.r, 32'h0); end
      checks++; if (dif.busy !== 1'b0)     begin failures++; $display("FAIL reset_busy got=%b exp=0", dif.busy); end
      checks++; if (dif.done !== 1'b0)     begin failures++; $display("FAIL reset_done got=%b exp=0", dif.done); end
      checks++; if (dif.stall_req !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", dif.stall_req); end
   endtask

   task automatic test_unsigned();
      int lat, st;
      logic [31:0] qv, rv;
      run_op(1'b0, 32'd100, 32'd7, lat, st, qv, rv);
      checks++; if (lat !== 33) begin failures++; $display("FAIL u100_7_latency got=%0d exp=33", lat); end
      checks++; if (st !== 33)  begin failures++; $display("FAIL u100_7_stall_cycles got=%0d exp=33", st); end
      checks++; if (qv !== 32'd14) begin failures++; $display("FAIL u100_7_q got=%h exp=%h", qv, 32'd14); end
      checks++; if (rv !== 32'd2)  begin failures++; $display("FAIL u100_7_r got=%h exp=%h", rv, 32'd2); end
      @(negedge clk);
      checks++; if (dif.busy !== 1'b0) begin failures++; $display("FAIL u100_7_no_restart_busy got=%b exp=0", dif.busy); end
      checks++; if (dif.done !== 1'b0) begin failures++; $display("FAIL u100_7_done_pulse got=%b exp=0", dif.done); end
      checks++; if (dif.stall_req !== 1'b0) begin failures++; $display("FAIL u100_7_idle_stall got=%b exp=0", dif.stall_req); end
   endtask

   task automatic test_signed();
      int lat, st;
      logic [31:0] qv, rv;
      run_op(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, lat, st, qv, rv);
      checks++; if (qv !== 32'hFFFF_FFFD) begin failures++; $display("FAIL s_m7_2_q got=%h exp=%h", qv, 32'hFFFF_FFFD); end
      checks++; if (rv !== 32'hFFFF_FFFF) begin failures++; $display("FAIL s_m7_2_r got=%h exp=%h", rv, 32'hFFFF_FFFF); end
      run_op(1'b1, 32'h0000_0007, 32'hFFFF_FFFE, lat, st, qv, rv);
      checks++; if (qv !== 32'hFFFF_FFFD) begin failures++; $display("FAIL s_7_m2_q got=%h exp=%h", qv, 32'hFFFF_FFFD); end
      checks++; if (rv !== 32'h0000_0001) begin failures++; $display("FAIL s_7_m2_r got=%h exp=%h", rv, 32'h0000_0001); end
   endtask

   task automatic test_edge();
      int lat, st;
      logic [31:0] qv, rv;
      run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, st, qv, rv);
      checks++; if (qv !== 32'h8000_0000) begin failures++; $display("FAIL s_min_m1_q got=%h exp=%h", qv, 32'h8000_0000); end
      checks++; if (rv !== 32'h0)         begin failures++; $display("FAIL s_min_m1_r got=%h exp=%h", rv, 32'h0); end
      run_op(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, lat, st, qv, rv);
      checks++; if (qv !== 32'hFFFF_FFFF) begin failures++; $display("FAIL u_max_1_q got=%h exp=%h", qv, 32'hFFFF_FFFF); end
      checks++; if (rv !== 32'h0)         begin failures++; $display("FAIL u_max_1_r got=%h exp=%h", rv, 32'h0); end
   endtask

   task automatic test_div_zero();
      int lat, st;
      logic [31:0] qv, rv;
      run_op(1'b1, 32'h1234_5678, 32'h0, lat, st, qv, rv);
      checks++; if (lat !== 33)           begin failures++; $display("FAIL s_dz_latency got=%0d exp=33", lat); end
      checks++; if (qv !== 32'hFFFF_FFFF) begin failures++; $display("FAIL s_dz_q got=%h exp=%h", qv, 32'hFFFF_FFFF); end
      checks++; if (rv !== 32'h1234_5678) begin failures++; $display("FAIL s_dz_r got=%h exp=%h", rv, 32'h1234_5678); end
      run_op(1'b0, 32'h1234_5678, 32'h0, lat, st, qv, rv);
      checks++; if (lat !== 33)           begin failures++; $display("FAIL u_dz_latency got=%0d exp=33", lat); end
      checks++; if (qv !== 32'hFFFF_FFFF) begin failures++; $display("FAIL u_dz_q got=%h exp=%h", qv, 32'hFFFF_FFFF); end
      checks++; if (rv !== 32'h1234_5678) begin failures++; $display("FAIL u_dz_r got=%h exp=%h", rv, 32'h1234_5678); end
   endtask

   task automatic test_flush();
      int lat, st, ndone;
      logic [31:0] qv, rv;
      @(posedge clk);
      #1;
      dif.ena      = 1'b1;
      dif.sign     = 1'b0;
      dif.dividend = 32'd1000;
      dif.divisor  = 32'd3;
      @(posedge clk);
      repeat (9) @(posedge clk);
      #1;
      checks++; if (dif.stall_req !== 1'b1) begin failures++; $display("FAIL flush_pre_stall got=%b exp=1", dif.stall_req); end
      dif.flush = 1'b1;
      #1;
      checks++; if (dif.stall_req !== 1'b0) begin failures++; $display("FAIL flush_stall_same_cycle got=%b exp=0", dif.stall_req); end
      checks++; if (dif.busy !== 1'b1)      begin failures++; $display("FAIL flush_busy_same_cycle got=%b exp=1", dif.busy); end
      @(posedge clk);
      #1;
      dif.flush = 1'b0;
      dif.ena   = 1'b0;
      checks++; if (dif.busy !== 1'b0) begin failures++; $display("FAIL flush_busy_next got=%b exp=0", dif.busy); end
      ndone = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (dif.done) ndone++;
      end
      checks++; if (ndone !== 0)             begin failures++; $display("FAIL flush_no_done got=%0d exp=0", ndone); end
      checks++; if (dif.q !== 32'hFFFF_FFFF) begin failures++; $display("FAIL flush_q_hold got=%h exp=%h", dif.q, 32'hFFFF_FFFF); end
      checks++; if (dif.r !== 32'h1234_5678) begin failures++; $display("FAIL flush_r_hold got=%h exp=%h", dif.r, 32'h1234_5678); end
      run_op(1'b0, 32'd9, 32'd3, lat, st, qv, rv);
      checks++; if (lat !== 33)    begin failures++; $display("FAIL reissue_latency got=%0d exp=33", lat); end
      checks++; if (qv !== 32'd3)  begin failures++; $display("FAIL reissue_q got=%h exp=%h", qv, 32'd3); end
      checks++; if (rv !== 32'd0)  begin failures++; $display("FAIL reissue_r got=%h exp=%h", rv, 32'd0); end
   endtask

   task automatic test_async_reset();
      int ndone;
      @(posedge clk);
      #1;
      dif.ena      = 1'b1;
      dif.sign     = 1'b0;
      dif.dividend = 32'd100;
      dif.divisor  = 32'd7;
      repeat (6) @(posedge clk);
      #3;
      checks++; if (dif.busy !== 1'b1) begin failures++; $display("FAIL arst_pre_busy got=%b exp=1", dif.busy); end
      dif.ena = 1'b0;
      rst     = 1'b1;
      #1;
      checks++; if (dif.q !== 32'h0)        begin failures++; $display("FAIL arst_q got=%h exp=%h", dif.q, 32'h0); end
      checks++; if (dif.r !== 32'h0)        begin failures++; $display("FAIL arst_r got=%h exp=%h", dif.r, 32'h0); end
      checks++; if (dif.busy !== 1'b0)      begin failures++; $display("FAIL arst_busy got=%b exp=0", dif.busy); end
      checks++; if (dif.done !== 1'b0)      begin failures++; $display("FAIL arst_done got=%b exp=0", dif.done); end
      checks++; if (dif.stall_req !== 1'b0) begin failures++; $display("FAIL arst_stall got=%b exp=0", dif.stall_req); end
      @(negedge clk);
      rst = 1'b0;
      ndone = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (dif.done) ndone++;
      end
      checks++; if (ndone !== 0) begin failures++; $display("FAIL arst_no_done got=%0d exp=0", ndone); end
   endtask

   task automatic test_back_to_back();
      int t1, t2;
      logic [31:0] q1, r1, q2, r2;
      t1 = -1; t2 = -1;
      q1 = '0; r1 = '0; q2 = '0; r2 = '0;
      @(posedge clk);
      #1;
      dif.ena      = 1'b1;
      dif.sign     = 1'b0;
      dif.dividend = 32'd20;
      dif.divisor  = 32'd6;
      for (int i = 0; i < 120; i++) begin
         @(negedge clk);
         if (dif.done) begin
            if (t1 < 0) begin
               t1 = i;
               q1 = dif.q;
               r1 = dif.r;
               @(posedge clk);
               #1;
               dif.dividend = 32'd50;
               dif.divisor  = 32'd5;
            end else begin
               t2 = i;
               q2 = dif.q;
               r2 = dif.r;
               break;
            end
         end
      end
      @(posedge clk);
      #1;
      dif.ena = 1'b0;
      checks++; if (t1 !== 33)      begin failures++; $display("FAIL b2b_first_latency got=%0d exp=33", t1); end
      checks++; if (t2 - t1 !== 34) begin failures++; $display("FAIL b2b_done_spacing got=%0d exp=34", t2 - t1); end
      checks++; if (q1 !== 32'd3)   begin failures++; $display("FAIL b2b_q1 got=%h exp=%h", q1, 32'd3); end
      checks++; if (r1 !== 32'd2)   begin failures++; $display("FAIL b2b_r1 got=%h exp=%h", r1, 32'd2); end
      checks++; if (q2 !== 32'd10)  begin failures++; $display("FAIL b2b_q2 got=%h exp=%h", q2, 32'd10); end
      checks++; if (r2 !== 32'd0)   begin failures++; $display("FAIL b2b_r2 got=%h exp=%h", r2, 32'd0); end
   endtask

   initial begin
      checks       = 0;
      failures     = 0;
      rst          = 1'b1;
      dif.ena      = 1'b0;
      dif.sign     = 1'b0;
      dif.dividend = '0;
      dif.divisor  = '0;
      dif.flush    = 1'b0;
      #12;
      test_reset();
      @(negedge clk);
      rst = 1'b0;
      test_unsigned();
      test_signed();
      test_edge();
      test_div_zero();
      test_flush();
      test_async_reset();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
